// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial little-endian loads/stores over an 8-bit RAM port.
// Stalls upstream for N cycles per N-byte access, then writes back in a DONE cycle.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [3:0]  ex_memop,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_mem_sdata,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        stall_req,
   output logic [31:0] ram_addr,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] ld_buf_q, ld_buf_d;
   logic [3:0]  op_q, op_d;

   logic [3:0]  cur_op;
   logic        is_load, is_store, sext;
   logic [1:0]  last;
   logic [7:0]  st_byte;
   logic [31:0] raw, ld_val;

   // The op is latched on entry so ACCESS/DONE never depend on ex_memop.
   assign cur_op = (state_q == StIdle) ? ex_memop : op_q;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      sext     = 1'b0;
      last     = 2'd0;
      case (cur_op)
         4'd1: begin is_load = 1'b1; sext = 1'b1; end
         4'd2: begin is_load = 1'b1; sext = 1'b1; last = 2'd1; end
         4'd3: begin is_load = 1'b1; last = 2'd3; end
         4'd4: is_load = 1'b1;
         4'd5: begin is_load = 1'b1; last = 2'd1; end
         4'd6: is_store = 1'b1;
         4'd7: begin is_store = 1'b1; last = 2'd1; end
         4'd8: begin is_store = 1'b1; last = 2'd3; end
         default: ;
      endcase
   end

   always_comb begin
      case (cnt_q)
         2'd0:    st_byte = ex_mem_sdata[7:0];
         2'd1:    st_byte = ex_mem_sdata[15:8];
         2'd2:    st_byte = ex_mem_sdata[23:16];
         default: st_byte = ex_mem_sdata[31:24];
      endcase
   end

   // Final byte arrives on ram_din in DONE; earlier bytes sit in the buffer.
   always_comb begin
      case (last)
         2'd0:    raw = {24'h0, ram_din};
         2'd1:    raw = {16'h0, ram_din, ld_buf_q[7:0]};
         default: raw = {ram_din, ld_buf_q};
      endcase
      ld_val = raw;
      if (sext && last == 2'd0) begin
         ld_val = {{24{raw[7]}}, raw[7:0]};
      end else if (sext && last == 2'd1) begin
         ld_val = {{16{raw[15]}}, raw[15:0]};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ld_buf_d  = ld_buf_q;
      op_d      = op_q;
      mem_wd    = 5'h0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'h0;
      stall_req = 1'b0;
      ram_addr  = 32'h0;
      ram_wr    = 1'b0;
      ram_dout  = 8'h0;
      case (state_q)
         StIdle: begin
            if (!is_load && !is_store) begin
               mem_wd    = ex_wd;
               mem_wreg  = ex_wreg;
               mem_wdata = ex_wdata;
            end else begin
               stall_req = 1'b1;
               ram_addr  = ex_mem_addr;
               ram_wr    = is_store;
               ram_dout  = is_store ? ex_mem_sdata[7:0] : 8'h0;
               op_d      = ex_memop;
               if (last == 2'd0) begin
                  state_d = StDone;
               end else begin
                  state_d = StAccess;
                  cnt_d   = 2'd1;
               end
            end
         end
         StAccess: begin
            stall_req = 1'b1;
            ram_addr  = ex_mem_addr + {30'h0, cnt_q};
            ram_wr    = is_store;
            ram_dout  = is_store ? st_byte : 8'h0;
            if (is_load) begin
               case (cnt_q)
                  2'd1:    ld_buf_d[7:0]   = ram_din;
                  2'd2:    ld_buf_d[15:8]  = ram_din;
                  2'd3:    ld_buf_d[23:16] = ram_din;
                  default: ;
               endcase
            end
            if (cnt_q == last) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StDone: begin
            if (is_load) begin
               mem_wd    = ex_wd;
               mem_wreg  = ex_wreg;
               mem_wdata = ld_val;
            end
            state_d = StIdle;
            cnt_d   = 2'd0;
         end
         default: state_d = StIdle;
      endcase
      if (rst) begin
         mem_wd    = 5'h0;
         mem_wreg  = 1'b0;
         mem_wdata = 32'h0;
         stall_req = 1'b0;
         ram_addr  = 32'h0;
         ram_wr    = 1'b0;
         ram_dout  = 8'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= 2'd0;
         ld_buf_q <= 24'h0;
         op_q     <= 4'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ld_buf_q <= ld_buf_d;
         op_q     <= op_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed RAM plus a reference memory model
// that predicts every cycle of each operation.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_mem_sdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stall_req;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;

   mem_stage dut (
      .clk         (clk),
      .rst         (rst),
      .ex_wd       (ex_wd),
      .ex_wreg     (ex_wreg),
      .ex_wdata    (ex_wdata),
      .ex_memop    (ex_memop),
      .ex_mem_addr (ex_mem_addr),
      .ex_mem_sdata(ex_mem_sdata),
      .mem_wd      (mem_wd),
      .mem_wreg    (mem_wreg),
      .mem_wdata   (mem_wdata),
      .stall_req   (stall_req),
      .ram_addr    (ram_addr),
      .ram_wr      (ram_wr),
      .ram_dout    (ram_dout),
      .ram_din     (ram_din)
   );

   always #5 clk = ~clk;

   // Observation vector: {stall, wr, addr[32], dout[8], wd[5], wreg, wdata[32]}
   typedef logic [79:0] obs_t;
   localparam obs_t DOUT_BITS = obs_t'(8'hFF) << 38;
   localparam obs_t ADDR_BITS = obs_t'(32'hFFFF_FFFF) << 46;

   logic [7:0] ram     [bit [31:0]];
   logic [7:0] ref_mem [bit [31:0]];
   obs_t trace [6];
   obs_t exp_tr [6];
   obs_t msk_tr [6];
   int   tr_len;
   int   compared = 0;
   int   mismatched = 0;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   always @(posedge clk) begin
      ram_din <= ram_rd(ram_addr);
      if (ram_wr) ram[ram_addr] = ram_dout;
   end

   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd4, 4'd6: return 1;
         4'd2, 4'd5, 4'd7: return 2;
         4'd3, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      ram[a] = d;
      ref_mem[a] = d;
   endtask

   // Predicts the full cycle trace of one op and applies stores to the reference memory.
   task automatic model_op(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] addr,
                           input logic [31:0] sdata);
      int n;
      logic ld, st;
      logic [31:0] raw, lv;
      n  = nbytes(op);
      ld = (op >= 4'd1 && op <= 4'd5);
      st = (op >= 4'd6 && op <= 4'd8);
      if (n == 0) begin
         exp_tr[0] = {2'b00, 32'h0, 8'h0, wd, wreg, wdata};
         msk_tr[0] = ~DOUT_BITS;
         return;
      end
      raw = 32'h0;
      for (int k = 0; k < n; k++) raw |= 32'(ref_rd(addr + 32'(k))) << (8 * k);
      case (op)
         4'd1:    lv = 32'($signed(raw[7:0]));
         4'd2:    lv = 32'($signed(raw[15:0]));
         default: lv = raw;
      endcase
      for (int k = 0; k < n; k++) begin
         exp_tr[k] = {1'b1, st, addr + 32'(k), st ? sdata[8*k +: 8] : 8'h0, 5'h0, 1'b0, 32'h0};
         msk_tr[k] = st ? '1 : ~DOUT_BITS;
         if (st) ref_mem[addr + 32'(k)] = sdata[8*k +: 8];
      end
      exp_tr[n] = {2'b00, 32'h0, 8'h0, ld ? wd : 5'h0, ld ? wreg : 1'b0, ld ? lv : 32'h0};
      msk_tr[n] = ~(DOUT_BITS | ADDR_BITS);
   endtask

   // Drives one op, records N+1 cycles (1 for NONE); called and returns at posedge+1.
   task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] addr,
                        input logic [31:0] sdata);
      model_op(op, wd, wreg, wdata, addr, sdata);
      ex_memop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
      ex_mem_addr = addr; ex_mem_sdata = sdata;
      tr_len = (nbytes(op) == 0) ? 1 : nbytes(op) + 1;
      for (int k = 0; k < tr_len; k++) begin
         @(negedge clk);
         trace[k] = {stall_req, ram_wr, ram_addr, ram_dout, mem_wd, mem_wreg, mem_wdata};
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      obs_t o;
      rst = 1'b1;
      ex_memop = 4'd3; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_F00D;
      ex_mem_addr = 32'h0000_0400; ex_mem_sdata = 32'h1111_2222;
      repeat (2) @(posedge clk);
      @(negedge clk);
      o = {stall_req, ram_wr, ram_addr, ram_dout, mem_wd, mem_wreg, mem_wdata};
      compared++;
      if (o !== 80'h0) begin
         mismatched++;
         $display("FAIL reset_memop: got %h want %h", o, 80'h0);
      end
      ex_memop = 4'd0;
      #1;
      o = {stall_req, ram_wr, ram_addr, ram_dout, mem_wd, mem_wreg, mem_wdata};
      compared++;
      if (o !== 80'h0) begin
         mismatched++;
         $display("FAIL reset_none: got %h want %h", o, 80'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_none();
      issue(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
      for (int k = 0; k < tr_len; k++) begin
         compared++;
         if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
            mismatched++;
            $display("FAIL none_fixed c%0d: got %h want %h", k, trace[k] & msk_tr[k],
                     exp_tr[k] & msk_tr[k]);
         end
      end
      for (int i = 9; i < 16; i++) begin
         issue(4'(i), 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
         compared++;
         if ((trace[0] & msk_tr[0]) !== (exp_tr[0] & msk_tr[0])) begin
            mismatched++;
            $display("FAIL none_op%0d: got %h want %h", i, trace[0] & msk_tr[0],
                     exp_tr[0] & msk_tr[0]);
         end
      end
   endtask

   task automatic test_lw();
      poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
      issue(4'd3, 5'd3, 1'b1, 32'h0, 32'h100, 32'h0);
      for (int k = 0; k < tr_len; k++) begin
         compared++;
         if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
            mismatched++;
            $display("FAIL lw c%0d: got %h want %h", k, trace[k] & msk_tr[k],
                     exp_tr[k] & msk_tr[k]);
         end
      end
      compared++;
      if (trace[4][31:0] !== 32'h1234_5678) begin
         mismatched++;
         $display("FAIL lw_value: got %h want %h", trace[4][31:0], 32'h1234_5678);
      end
   endtask

   task automatic test_load_ext();
      logic [3:0]  ops  [3] = '{4'd1, 4'd4, 4'd2};
      logic [31:0] adrs [3] = '{32'h20, 32'h20, 32'h21};
      logic [31:0] want [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF01};
      poke(32'h20, 8'h80); poke(32'h21, 8'h01); poke(32'h22, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], 5'd17, 1'b1, 32'h0, adrs[i], 32'h0);
         for (int k = 0; k < tr_len; k++) begin
            compared++;
            if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
               mismatched++;
               $display("FAIL ext_op%0d c%0d: got %h want %h", ops[i], k,
                        trace[k] & msk_tr[k], exp_tr[k] & msk_tr[k]);
            end
         end
         compared++;
         if (trace[tr_len-1][31:0] !== want[i]) begin
            mismatched++;
            $display("FAIL ext_value op%0d: got %h want %h", ops[i], trace[tr_len-1][31:0],
                     want[i]);
         end
      end
   endtask

   task automatic test_sw_wrap();
      logic [31:0] a [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      logic [7:0]  d [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      issue(4'd8, 5'd4, 1'b1, 32'h55, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
      for (int k = 0; k < tr_len; k++) begin
         compared++;
         if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
            mismatched++;
            $display("FAIL sw_wrap c%0d: got %h want %h", k, trace[k] & msk_tr[k],
                     exp_tr[k] & msk_tr[k]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (ram_rd(a[i]) !== d[i]) begin
            mismatched++;
            $display("FAIL sw_ram[%h]: got %h want %h", a[i], ram_rd(a[i]), d[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      obs_t o;
      ex_memop = 4'd3; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h0;
      ex_mem_addr = 32'h200; ex_mem_sdata = 32'h0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      compared++;
      if ({stall_req, ram_addr} !== {1'b1, 32'h202}) begin
         mismatched++;
         $display("FAIL abort_pre: got %h want %h", {stall_req, ram_addr}, {1'b1, 32'h202});
      end
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         o = {stall_req, ram_wr, ram_addr, ram_dout, mem_wd, mem_wreg, mem_wdata};
         compared++;
         if (o !== 80'h0) begin
            mismatched++;
            $display("FAIL abort_rst c%0d: got %h want %h", c, o, 80'h0);
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
      compared++;
      if ((trace[0] & msk_tr[0]) !== (exp_tr[0] & msk_tr[0])) begin
         mismatched++;
         $display("FAIL abort_after: got %h want %h", trace[0] & msk_tr[0],
                  exp_tr[0] & msk_tr[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  b;
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         a = $urandom;
         poke(a, ~b);
         issue(4'd6, 5'd1, 1'b1, 32'h0, a, {24'($urandom), b});
         for (int k = 0; k < tr_len; k++) begin
            compared++;
            if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
               mismatched++;
               $display("FAIL b2b_sb c%0d: got %h want %h", k, trace[k] & msk_tr[k],
                        exp_tr[k] & msk_tr[k]);
            end
         end
         issue(4'd4, 5'd12, 1'b1, 32'h0, a, 32'h0);
         for (int k = 0; k < tr_len; k++) begin
            compared++;
            if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
               mismatched++;
               $display("FAIL b2b_lbu c%0d: got %h want %h", k, trace[k] & msk_tr[k],
                        exp_tr[k] & msk_tr[k]);
            end
         end
         compared++;
         if (trace[1][31:0] !== {24'h0, b}) begin
            mismatched++;
            $display("FAIL b2b_value: got %h want %h", trace[1][31:0], {24'h0, b});
         end
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] base [3] = '{32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_1000};
      for (int i = 0; i < 150; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
         issue(op, 5'($urandom), 1'($urandom), $urandom,
               base[$urandom_range(0, 2)] + 32'($urandom_range(0, 15)), $urandom);
         for (int k = 0; k < tr_len; k++) begin
            compared++;
            if ((trace[k] & msk_tr[k]) !== (exp_tr[k] & msk_tr[k])) begin
               mismatched++;
               $display("FAIL rand%0d op%0d c%0d: got %h want %h", i, op, k,
                        trace[k] & msk_tr[k], exp_tr[k] & msk_tr[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_none();
      test_lw();
      test_load_ext();
      test_sw_wrap();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
